// File: rtl/alu_defs.sv
// Shared ALU control codes and the multiply-sequencer state encoding.
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU. SLT compares unsigned, which the multiplier
// relies on to recover the adder carry.
module alu
  import alu_defs::*;
(
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select
  always_comb begin
    result = '0;
    case (control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'b0, (a < b)};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mult_sequencer.sv
// Iterative unsigned 32x32 shift-add multiplier driving two ALU instances:
// one forms Hi + Mcand, the other recovers the carry as (Sum < Hi).
module mult_sequencer
  import alu_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] Product
);

  mult_state_e state, next_state;
  logic [4:0]  count;
  logic [31:0] mcand, hi, lo;
  logic [31:0] sum, ltu_word;
  logic        carry;
  logic        zero_add, zero_ltu;
  logic        unused_bits;

  alu u_alu_add (
    .control (ALU_ADD),
    .a       (hi),
    .b       (mcand),
    .result  (sum),
    .zero    (zero_add)
  );

  alu u_alu_carry (
    .control (ALU_SLT),
    .a       (sum),
    .b       (hi),
    .result  (ltu_word),
    .zero    (zero_ltu)
  );

  assign carry       = ltu_word[0];
  assign unused_bits = zero_add | zero_ltu | (|ltu_word[31:1]);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: Start only matters in IDLE, DONE always returns to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = RUN;
      RUN:     if (count == 5'd31) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture and one shift-add step per RUN cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE && Start) begin
      count <= '0;
      mcand <= Multiplicand;
      hi    <= '0;
      lo    <= Multiplier;
    end else if (state == RUN) begin
      if (lo[0]) {hi, lo} <= {carry, sum, lo[31:1]};
      else       {hi, lo} <= {1'b0, hi, lo[31:1]};
      if (count != 5'd31) count <= count + 5'd1;
    end
  end

  assign Busy    = (state == RUN);
  assign Done    = (state == DONE);
  assign Product = {hi, lo};

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner cases plus
// random operands, all checked against plain 64-bit multiplication.
module tb_mult_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] Multiplicand = '0;
  logic [31:0] Multiplier = '0;
  logic        Busy, Done;
  logic [63:0] Product;

  int n_chk  = 0;
  int n_pass = 0;

  mult_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Busy         (Busy),
    .Done         (Done),
    .Product      (Product)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Launch an op, optionally poke Start with 1x1 after `inject` busy cycles,
  // wait for Done and check busy length, product and single-cycle pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int inject, input string tag);
    int busy_n;
    int t;
    @(negedge clock);
    Start = 1'b1; Multiplicand = a; Multiplier = b;
    @(negedge clock);
    Start = 1'b0; Multiplicand = $urandom; Multiplier = $urandom;
    busy_n = 0; t = 0;
    while (!Done && t < 100) begin
      if (Busy) busy_n++;
      if (inject > 0 && busy_n == inject) begin
        Start = 1'b1; Multiplicand = 32'd1; Multiplier = 32'd1;
      end else begin
        Start = 1'b0;
      end
      @(negedge clock);
      t++;
    end
    Start = 1'b0;
    chk({tag, " done_seen"}, 64'(Done), 64'd1);
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
    chk({tag, " product"}, Product, ref_mul(a, b));
    @(negedge clock);
    chk({tag, " done_pulse"}, 64'(Done), 64'd0);
  endtask

  // After an op, leave the block idle and confirm the result sticks.
  task automatic hold_check(input logic [63:0] exp, input string tag);
    int busy_seen;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (Busy || Done) busy_seen++;
    end
    chk({tag, " hold_product"}, Product, exp);
    chk({tag, " hold_idle"}, 64'(busy_seen), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int t, gap, spur;

    // Reset state
    #12;
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst done", 64'(Done), 64'd0);
    chk("rst product", Product, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Basic and maximum operands
    run_op(32'd3, 32'd5, 0, "basic");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max");
    chk("max literal", Product, 64'hFFFF_FFFE_0000_0001);

    // Zero and hold
    run_op(32'h1234_5678, 32'd0, 0, "zero");
    hold_check(64'd0, "zero");
    run_op(32'h8000_0000, 32'd2, 0, "msb");
    chk("msb literal", Product, 64'h0000_0001_0000_0000);
    hold_check(64'h0000_0001_0000_0000, "msb");

    // Start while busy is ignored; no second op follows
    run_op(32'd7, 32'd9, 10, "busy_start");
    hold_check(64'h3F, "busy_start");

    // Asynchronous reset mid-run
    @(negedge clock);
    Start = 1'b1; Multiplicand = 32'hDEAD_BEEF; Multiplier = 32'h1357_9BDF;
    @(negedge clock);
    Start = 1'b0;
    repeat (14) @(negedge clock);
    chk("abort pre busy", 64'(Busy), 64'd1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 64'(Busy), 64'd0);
    chk("abort done", 64'(Done), 64'd0);
    chk("abort product", Product, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    spur = 0;
    repeat (40) begin
      @(negedge clock);
      if (Done || Busy) spur++;
    end
    chk("abort no_done", 64'(spur), 64'd0);
    run_op(32'd6, 32'd7, 0, "after_abort");
    chk("after_abort literal", Product, 64'h2A);

    // Back-to-back with Start held through DONE
    @(negedge clock);
    Start = 1'b1; Multiplicand = 32'd2; Multiplier = 32'd3;
    @(negedge clock);
    Multiplicand = 32'd4; Multiplier = 32'd5;
    t = 0;
    while (!Done && t < 100) begin @(negedge clock); t++; end
    chk("b2b first done", 64'(Done), 64'd1);
    chk("b2b first product", Product, 64'd6);
    @(negedge clock);
    chk("b2b idle gap", 64'(Busy), 64'd0);
    @(negedge clock);
    chk("b2b second accepted", 64'(Busy), 64'd1);
    Start = 1'b0;
    gap = 2;
    while (!Done && gap < 100) begin @(negedge clock); gap++; end
    chk("b2b done spacing", 64'(gap), 64'd34);
    chk("b2b second product", Product, 64'h14);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0001;
      if (i == 1) rb = 32'hFFFF_FFFF;
      run_op(ra, rb, 0, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
